// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs, status codes and
// the D->E pipeline payload with its bubble value.
package y86_pkg;

  localparam int unsigned Y86_WORD = 64;
  localparam int unsigned Y86_NREG = 15;
  localparam int unsigned RID_W    = 4;

  typedef logic [RID_W-1:0] reg_id_t;
  typedef logic [3:0]       icode_t;

  localparam icode_t IHALT   = 4'h0;
  localparam icode_t INOP    = 4'h1;
  localparam icode_t IRRMOVQ = 4'h2;
  localparam icode_t IIRMOVQ = 4'h3;
  localparam icode_t IRMMOVQ = 4'h4;
  localparam icode_t IMRMOVQ = 4'h5;
  localparam icode_t IOPQ    = 4'h6;
  localparam icode_t IJXX    = 4'h7;
  localparam icode_t ICALL   = 4'h8;
  localparam icode_t IRET    = 4'h9;
  localparam icode_t IPUSHQ  = 4'hA;
  localparam icode_t IPOPQ   = 4'hB;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RRSP  = 4'h4;

  typedef enum logic [1:0] {
    SAOK = 2'd0,
    SHLT = 2'd1,
    SADR = 2'd2,
    SINS = 2'd3
  } stat_e;

  typedef struct packed {
    stat_e                stat;
    icode_t               icode;
    logic [3:0]           ifun;
    logic [Y86_WORD-1:0]  val_c;
    logic [Y86_WORD-1:0]  val_p;
    logic [Y86_WORD-1:0]  val_a;
    logic [Y86_WORD-1:0]  val_b;
    reg_id_t              src_a;
    reg_id_t              src_b;
    reg_id_t              dst_e;
    reg_id_t              dst_m;
  } de_t;

  localparam de_t NOP_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    ifun:  4'h0,
    val_c: '0,
    val_p: '0,
    val_a: '0,
    val_b: '0,
    src_a: RNONE,
    src_b: RNONE,
    dst_e: RNONE,
    dst_m: RNONE
  };

  // Memory error outranks an invalid encoding, which outranks halt.
  function automatic stat_e decode_stat(input logic imem_error,
                                        input logic instr_valid,
                                        input icode_t icode);
    stat_e s;
    if (imem_error)         s = SADR;
    else if (!instr_valid)  s = SINS;
    else if (icode == IHALT) s = SHLT;
    else                    s = SAOK;
    return s;
  endfunction

endpackage

// File: rtl/decode_regfile_if.sv
// Fetch/write-back/control inputs and D->E pipeline outputs of the decode stage.
interface decode_regfile_if;
  import y86_pkg::*;

  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [3:0]          rA;
  logic [3:0]          rB;
  logic [Y86_WORD-1:0] valC;
  logic [Y86_WORD-1:0] valP;
  logic                instr_valid;
  logic                imem_error;
  logic                cnd;
  logic [3:0]          w_dstE;
  logic [3:0]          w_dstM;
  logic [Y86_WORD-1:0] w_valE;
  logic [Y86_WORD-1:0] w_valM;
  logic                stall;
  logic                bubble;

  logic [1:0]          e_stat;
  logic [3:0]          e_icode;
  logic [3:0]          e_ifun;
  logic [Y86_WORD-1:0] e_valC;
  logic [Y86_WORD-1:0] e_valP;
  logic [Y86_WORD-1:0] e_valA;
  logic [Y86_WORD-1:0] e_valB;
  logic [3:0]          e_srcA;
  logic [3:0]          e_srcB;
  logic [3:0]          e_dstE;
  logic [3:0]          e_dstM;

  modport master (
    output icode, ifun, rA, rB, valC, valP, instr_valid, imem_error, cnd,
           w_dstE, w_dstM, w_valE, w_valM, stall, bubble,
    input  e_stat, e_icode, e_ifun, e_valC, e_valP, e_valA, e_valB,
           e_srcA, e_srcB, e_dstE, e_dstM
  );

  modport slave (
    input  icode, ifun, rA, rB, valC, valP, instr_valid, imem_error, cnd,
           w_dstE, w_dstM, w_valE, w_valM, stall, bubble,
    output e_stat, e_icode, e_ifun, e_valC, e_valP, e_valA, e_valB,
           e_srcA, e_srcB, e_dstE, e_dstM
  );

endinterface

// File: rtl/regfile.sv
// NREG x WORD register array: two combinational read ports, two write ports
// where the M port wins on a shared ID; IDs >= NREG read 0 and never write.
module regfile #(
  parameter int unsigned WORD = 64,
  parameter int unsigned NREG = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      rd_a_i,
  input  logic [3:0]      rd_b_i,
  output logic [WORD-1:0] rd_a_data_c_o,
  output logic [WORD-1:0] rd_b_data_c_o,
  input  logic [3:0]      wr_e_id_i,
  input  logic [3:0]      wr_m_id_i,
  input  logic [WORD-1:0] wr_e_data_i,
  input  logic [WORD-1:0] wr_m_data_i
);

  logic [WORD-1:0] regs_q [NREG];
  logic [WORD-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (wr_m_id_i == 4'(i))      regs_d[i] = wr_m_data_i;
      else if (wr_e_id_i == 4'(i)) regs_d[i] = wr_e_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_a_data_c_o = (32'(rd_a_i) < NREG) ? regs_q[rd_a_i] : '0;
  assign rd_b_data_c_o = (32'(rd_b_i) < NREG) ? regs_q[rd_b_i] : '0;

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode/write-back stage: register-ID decode, operand read with
// same-cycle write-back bypass, and the stall/bubble D->E pipeline register.
module decode_regfile
  import y86_pkg::*;
#(
  parameter int unsigned WORD = 64,
  parameter int unsigned NREG = 15
) (
  input logic              clk,
  input logic              rst_n,
  decode_regfile_if.slave  dbus
);

  reg_id_t         src_a;
  reg_id_t         src_b;
  reg_id_t         dst_e;
  reg_id_t         dst_m;
  logic [WORD-1:0] rf_a;
  logic [WORD-1:0] rf_b;
  logic [WORD-1:0] val_a;
  logic [WORD-1:0] val_b;
  stat_e           stat;
  de_t             de_d;
  de_t             de_q;

  // Source/destination register selection from the instruction class.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (dbus.icode)
      IRRMOVQ: begin
        src_a = dbus.rA;
        dst_e = dbus.cnd ? dbus.rB : RNONE;
      end
      IIRMOVQ: dst_e = dbus.rB;
      IRMMOVQ: begin
        src_a = dbus.rA;
        src_b = dbus.rB;
      end
      IMRMOVQ: begin
        src_b = dbus.rB;
        dst_m = dbus.rA;
      end
      IOPQ: begin
        src_a = dbus.rA;
        src_b = dbus.rB;
        dst_e = dbus.rB;
      end
      ICALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      IRET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPUSHQ: begin
        src_a = dbus.rA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPOPQ: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = dbus.rA;
      end
      default: ;
    endcase
  end

  assign stat = decode_stat(dbus.imem_error, dbus.instr_valid, dbus.icode);

  regfile #(
    .WORD (WORD),
    .NREG (NREG)
  ) u_regfile (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_a_i        (src_a),
    .rd_b_i        (src_b),
    .rd_a_data_c_o (rf_a),
    .rd_b_data_c_o (rf_b),
    .wr_e_id_i     (dbus.w_dstE),
    .wr_m_id_i     (dbus.w_dstM),
    .wr_e_data_i   (dbus.w_valE),
    .wr_m_data_i   (dbus.w_valM)
  );

  // Forward this cycle's write-back data; M is checked first so it wins a tie.
  function automatic logic [WORD-1:0] bypass(input reg_id_t id,
                                             input logic [WORD-1:0] rf_val,
                                             input reg_id_t w_dst_e,
                                             input reg_id_t w_dst_m,
                                             input logic [WORD-1:0] w_val_e,
                                             input logic [WORD-1:0] w_val_m);
    logic [WORD-1:0] v;
    if (id == RNONE)        v = '0;
    else if (id == w_dst_m) v = w_val_m;
    else if (id == w_dst_e) v = w_val_e;
    else                    v = rf_val;
    return v;
  endfunction

  assign val_a = bypass(src_a, rf_a, dbus.w_dstE, dbus.w_dstM, dbus.w_valE, dbus.w_valM);
  assign val_b = bypass(src_b, rf_b, dbus.w_dstE, dbus.w_dstM, dbus.w_valE, dbus.w_valM);

  // Stall dominates bubble; register-file writes proceed regardless.
  always_comb begin
    de_d = de_q;
    if (dbus.stall) begin
      de_d = de_q;
    end else if (dbus.bubble) begin
      de_d = NOP_BUBBLE;
    end else begin
      de_d.stat  = stat;
      de_d.icode = dbus.icode;
      de_d.ifun  = dbus.ifun;
      de_d.val_c = dbus.valC;
      de_d.val_p = dbus.valP;
      de_d.val_a = val_a;
      de_d.val_b = val_b;
      de_d.src_a = src_a;
      de_d.src_b = src_b;
      de_d.dst_e = dst_e;
      de_d.dst_m = dst_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) de_q <= NOP_BUBBLE;
    else        de_q <= de_d;
  end

  assign dbus.e_stat  = de_q.stat;
  assign dbus.e_icode = de_q.icode;
  assign dbus.e_ifun  = de_q.ifun;
  assign dbus.e_valC  = de_q.val_c;
  assign dbus.e_valP  = de_q.val_p;
  assign dbus.e_valA  = de_q.val_a;
  assign dbus.e_valB  = de_q.val_b;
  assign dbus.e_srcA  = de_q.src_a;
  assign dbus.e_srcB  = de_q.src_b;
  assign dbus.e_dstE  = de_q.dst_e;
  assign dbus.e_dstM  = de_q.dst_m;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed plus randomized checks of decode_regfile against a behavioural
// model: register array as a plain array, D->E register as expected fields.
module tb_decode_regfile;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_regfile_if dbus ();

  decode_regfile u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbus  (dbus)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] mregs [15];
  logic [1:0]  x_stat;
  logic [3:0]  x_icode, x_ifun, x_srca, x_srcb, x_dste, x_dstm;
  logic [63:0] x_valc, x_valp, x_vala, x_valb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stat"},  64'(dbus.e_stat),  64'(x_stat));
    check({tag, ".icode"}, 64'(dbus.e_icode), 64'(x_icode));
    check({tag, ".ifun"},  64'(dbus.e_ifun),  64'(x_ifun));
    check({tag, ".valC"},  dbus.e_valC,       x_valc);
    check({tag, ".valP"},  dbus.e_valP,       x_valp);
    check({tag, ".valA"},  dbus.e_valA,       x_vala);
    check({tag, ".valB"},  dbus.e_valB,       x_valb);
    check({tag, ".srcA"},  64'(dbus.e_srcA),  64'(x_srca));
    check({tag, ".srcB"},  64'(dbus.e_srcB),  64'(x_srcb));
    check({tag, ".dstE"},  64'(dbus.e_dstE),  64'(x_dste));
    check({tag, ".dstM"},  64'(dbus.e_dstM),  64'(x_dstm));
  endtask

  function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB})             return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h2)                         return c ? rb : 4'hF;
    if (ic inside {4'h3, 4'h6})             return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
    x_stat = 2'd0; x_icode = 4'h1; x_ifun = 4'h0;
    x_valc = 64'h0; x_valp = 64'h0; x_vala = 64'h0; x_valb = 64'h0;
    x_srca = 4'hF; x_srcb = 4'hF; x_dste = 4'hF; x_dstm = 4'hF;
  endtask

  // Operands are read from the array as it will look after this edge's writes.
  task automatic tick();
    logic [63:0] nxt [15];
    logic [3:0]  sa, sb;
    nxt = mregs;
    if (dbus.w_dstE != 4'hF) nxt[dbus.w_dstE] = dbus.w_valE;
    if (dbus.w_dstM != 4'hF) nxt[dbus.w_dstM] = dbus.w_valM;
    if (!dbus.stall) begin
      if (dbus.bubble) begin
        x_stat = 2'd0; x_icode = 4'h1; x_ifun = 4'h0;
        x_valc = 64'h0; x_valp = 64'h0; x_vala = 64'h0; x_valb = 64'h0;
        x_srca = 4'hF; x_srcb = 4'hF; x_dste = 4'hF; x_dstm = 4'hF;
      end else begin
        sa = m_srca(dbus.icode, dbus.rA);
        sb = m_srcb(dbus.icode, dbus.rB);
        x_stat  = dbus.imem_error ? 2'd2 : !dbus.instr_valid ? 2'd3 :
                  (dbus.icode == 4'h0) ? 2'd1 : 2'd0;
        x_icode = dbus.icode;
        x_ifun  = dbus.ifun;
        x_valc  = dbus.valC;
        x_valp  = dbus.valP;
        x_srca  = sa;
        x_srcb  = sb;
        x_vala  = (sa == 4'hF) ? 64'h0 : nxt[sa];
        x_valb  = (sb == 4'hF) ? 64'h0 : nxt[sb];
        x_dste  = m_dste(dbus.icode, dbus.rB, dbus.cnd);
        x_dstm  = m_dstm(dbus.icode, dbus.rA);
      end
    end
    @(posedge clk);
    #1;
    mregs = nxt;
  endtask

  task automatic set_fetch(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [3:0] ra, input logic [3:0] rb);
    dbus.icode = ic;
    dbus.ifun  = fn;
    dbus.rA    = ra;
    dbus.rB    = rb;
    dbus.valC  = {$urandom, $urandom};
    dbus.valP  = {$urandom, $urandom};
  endtask

  task automatic set_wb(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
    dbus.w_dstE = de;
    dbus.w_valE = ve;
    dbus.w_dstM = dm;
    dbus.w_valM = vm;
  endtask

  task automatic set_ctrl(input logic valid, input logic err, input logic c,
                          input logic st, input logic bb);
    dbus.instr_valid = valid;
    dbus.imem_error  = err;
    dbus.cnd         = c;
    dbus.stall       = st;
    dbus.bubble      = bb;
  endtask

  initial begin
    // Reset with random inputs on every port.
    set_fetch(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    set_wb(4'($urandom_range(0, 14)), {$urandom, $urandom}, 4'($urandom_range(0, 14)), {$urandom, $urandom});
    set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.icode", 64'(dbus.e_icode), 64'h1);
    check("rst.dstE",  64'(dbus.e_dstE),  64'hF);
    check("rst.dstM",  64'(dbus.e_dstM),  64'hF);
    check("rst.valA",  dbus.e_valA,       64'h0);
    @(posedge clk);
    #1;
    check_all("rst_hold");

    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      set_fetch(4'h6, 4'h0, 4'(i), 4'(i));
      tick();
      check_all("rd_zero");
      check("rd_zero.lit", dbus.e_valA | dbus.e_valB, 64'h0);
    end

    // Write then read back through OPq.
    set_wb(4'h3, 64'h1234, 4'hF, 64'h0);
    set_fetch(4'h1, 4'h0, 4'hF, 4'hF);
    tick();
    check_all("wr3");
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_fetch(4'h6, 4'h0, 4'h3, 4'h3);
    tick();
    check_all("rd3");
    check("rd3.valA", dbus.e_valA, 64'h1234);
    check("rd3.valB", dbus.e_valB, 64'h1234);
    check("rd3.dstE", 64'(dbus.e_dstE), 64'h3);

    // Same-ID write on both ports: M wins, bypassed and then stored.
    set_wb(4'h4, 64'hAA, 4'h4, 64'hBB);
    set_fetch(4'hA, 4'h0, 4'h4, 4'hF);
    tick();
    check_all("byp");
    check("byp.valA", dbus.e_valA, 64'hBB);
    check("byp.valB", dbus.e_valB, 64'hBB);
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_fetch(4'hB, 4'h0, 4'hF, 4'hF);
    tick();
    check_all("rsp");
    check("rsp.valA", dbus.e_valA, 64'hBB);

    // cmov qualified by cnd.
    set_fetch(4'h2, 4'h2, 4'h1, 4'h2);
    dbus.cnd = 1'b0;
    tick();
    check_all("cmov0");
    check("cmov0.dstE", 64'(dbus.e_dstE), 64'hF);
    dbus.cnd = 1'b1;
    tick();
    check_all("cmov1");
    check("cmov1.dstE", 64'(dbus.e_dstE), 64'h2);

    // Status priority.
    set_fetch(4'h6, 4'h0, 4'h1, 4'h2);
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("stat.adr", 64'(dbus.e_stat), 64'h2);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("stat.ins", 64'(dbus.e_stat), 64'h3);
    set_fetch(4'h0, 4'h0, 4'hF, 4'hF);
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("stat.hlt", 64'(dbus.e_stat), 64'h1);
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("stat.adr_ins", 64'(dbus.e_stat), 64'h2);
    check_all("stat");

    // Stall holds for two cycles while writes still land.
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_fetch(4'h3, 4'h0, 4'hF, 4'h7);
    tick();
    check_all("pre_stall");
    dbus.stall = 1'b1;
    set_fetch(4'h6, 4'h1, 4'h2, 4'h3);
    set_wb(4'h7, 64'h55, 4'hF, 64'h0);
    tick();
    check_all("stall1");
    check("stall1.icode", 64'(dbus.e_icode), 64'h3);
    set_wb(4'hF, 64'h0, 4'h8, 64'h66);
    tick();
    check_all("stall2");
    check("stall2.dstE", 64'(dbus.e_dstE), 64'h7);
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    dbus.stall  = 1'b0;
    dbus.bubble = 1'b1;
    tick();
    check_all("bubble");
    check("bubble.icode", 64'(dbus.e_icode), 64'h1);
    check("bubble.dstE",  64'(dbus.e_dstE),  64'hF);
    dbus.bubble = 1'b0;
    set_fetch(4'h6, 4'h0, 4'h7, 4'h8);
    tick();
    check_all("stall_wr");
    check("stall_wr.valA", dbus.e_valA, 64'h55);
    check("stall_wr.valB", dbus.e_valB, 64'h66);
    dbus.stall  = 1'b1;
    dbus.bubble = 1'b1;
    set_fetch(4'h5, 4'h0, 4'h1, 4'h2);
    tick();
    check_all("stall_bubble");
    check("stall_bubble.icode", 64'(dbus.e_icode), 64'h6);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      set_fetch(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      set_wb(($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)), {$urandom, $urandom},
             ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14)), {$urandom, $urandom});
      set_ctrl($urandom_range(0, 15) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      tick();
      check_all("rand");
    end

    // Reset across a write edge: the write is lost.
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_wb(4'h5, 64'hDEAD, 4'hF, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_fetch(4'h6, 4'h0, 4'h5, 4'h5);
    tick();
    check_all("midrst_rd");
    check("midrst_rd.valA", dbus.e_valA, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
